// File: rtl/fixed_p_pkg.sv
// Shared fixed-point types: sequencing states for the iterative divider.
package fixed_p_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } div_state_e;

endpackage

// File: rtl/fixed_p_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, compare, subtract.
module fixed_p_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] divisor_ext;
    logic [WIDTH:0]   diff;

    always_comb begin
        shifted     = {rem_in, bit_in};
        divisor_ext = {2'b00, divisor};
        q_bit       = (shifted >= divisor_ext);
        // The kept remainder is always below the divisor, so the top bit drops cleanly.
        diff        = shifted[WIDTH:0] - divisor_ext[WIDTH:0];
        rem_out     = q_bit ? diff : shifted[WIDTH:0];
    end

endmodule

// File: rtl/fixed_p_std_div_pipe.sv
// Unsigned fixed-point divider, one quotient bit per cycle (restoring, MSB first).
module fixed_p_std_div_pipe
    import fixed_p_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int INT_WIDTH   = 8,
    parameter int FRACT_WIDTH = 24,
    parameter int SATURATE    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic             overflow,
    output logic             done
);

    localparam int D     = WIDTH + FRACT_WIDTH;
    localparam int CNT_W = $clog2(D);

    generate
        if (WIDTH != INT_WIDTH + FRACT_WIDTH) begin : g_bad_width
            $error("fixed_p_std_div_pipe: WIDTH must equal INT_WIDTH + FRACT_WIDTH");
        end
    endgenerate

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [D-1:0]     dvd_q, dvd_d;
    logic [D-2:0]     quot_q, quot_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] out_quo_q, out_quo_d;
    logic [WIDTH-1:0] out_rem_q, out_rem_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   step_rem;
    logic             step_bit;
    logic [D-1:0]     full_quot;
    logic             full_ovf;

    fixed_p_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .bit_in  (dvd_q[D-1]),
        .divisor (div_q),
        .rem_out (step_rem),
        .q_bit   (step_bit)
    );

    assign full_quot = {quot_q, step_bit};
    assign full_ovf  = |full_quot[D-1:WIDTH];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        div_d     = div_q;
        out_quo_d = out_quo_q;
        out_rem_d = out_rem_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    if (right != '0) begin
                        dvd_d   = {left, {FRACT_WIDTH{1'b0}}};
                        div_d   = right;
                        rem_d   = '0;
                        quot_d  = '0;
                        cnt_d   = '0;
                        state_d = ST_RUN;
                    end else begin
                        // Divide by zero bypasses the iteration entirely.
                        out_quo_d = '1;
                        out_rem_d = left;
                        ovf_d     = 1'b1;
                        done_d    = 1'b1;
                        state_d   = ST_FIN;
                    end
                end
            end
            ST_RUN: begin
                dvd_d  = dvd_q << 1;
                rem_d  = step_rem;
                quot_d = full_quot[D-2:0];
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(D - 1)) begin
                    // Results land with the last step so they are valid while done is high.
                    out_quo_d = (full_ovf && (SATURATE != 0)) ? '1 : full_quot[WIDTH-1:0];
                    out_rem_d = step_rem[WIDTH-1:0];
                    ovf_d     = full_ovf;
                    done_d    = 1'b1;
                    state_d   = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            div_q     <= '0;
            out_quo_q <= '0;
            out_rem_q <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            div_q     <= div_d;
            out_quo_q <= out_quo_d;
            out_rem_q <= out_rem_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    assign out_quotient  = out_quo_q;
    assign out_remainder = out_rem_q;
    assign overflow      = ovf_q;
    assign done          = done_q;

endmodule

// File: tb/tb_fixed_p_std_div_pipe.sv
// Directed bench for the 8-bit (4.4) divider, saturating and wrapping variants side by side.
module tb_fixed_p_std_div_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic       go;
    logic [7:0] left, right;
    logic [7:0] q_s, r_s, q_w, r_w;
    logic       ov_s, ov_w, done_s, done_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fixed_p_std_div_pipe #(.WIDTH(8), .INT_WIDTH(4), .FRACT_WIDTH(4), .SATURATE(1)) dut_sat (
        .clk(clk), .reset(reset), .go(go), .left(left), .right(right),
        .out_quotient(q_s), .out_remainder(r_s), .overflow(ov_s), .done(done_s)
    );

    fixed_p_std_div_pipe #(.WIDTH(8), .INT_WIDTH(4), .FRACT_WIDTH(4), .SATURATE(0)) dut_wrap (
        .clk(clk), .reset(reset), .go(go), .left(left), .right(right),
        .out_quotient(q_w), .out_remainder(r_w), .overflow(ov_w), .done(done_w)
    );

    typedef struct {
        logic [7:0] l;
        logic [7:0] r;
        int         lat;
        logic [7:0] q;
        logic [7:0] rem;
        logic       ov;
        logic [7:0] q_wrap;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic void ref_div(input logic [7:0] l, input logic [7:0] r,
                                    output logic [7:0] q, output logic [7:0] rem,
                                    output logic ov);
        logic [11:0] num, qq, rr;
        num = {l, 4'b0000};
        qq  = num / {4'b0000, r};
        rr  = num % {4'b0000, r};
        ov  = (qq > 12'd255);
        q   = ov ? 8'hFF : qq[7:0];
        rem = rr[7:0];
    endfunction

    task automatic run_op(input vec_t v);
        int lat;
        @(negedge clk);
        go = 1'b1; left = v.l; right = v.r;
        @(posedge clk); #1;
        go = 1'b0;
        lat = 1;
        while (!done_s && lat < 40) begin
            @(negedge clk);
            left = 8'($urandom); right = 8'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, v.lat);
        check("quotient", q_s, v.q);
        check("remainder", r_s, v.rem);
        check("overflow", ov_s, v.ov);
        check("quotient_wrap", q_w, v.q_wrap);
        check("done_wrap", done_w, 1);
        @(posedge clk); #1;
        check("done_single_cycle", done_s, 0);
    endtask

    vec_t vecs[9];

    initial begin
        logic [7:0] l0, r0, l1, r1, eq, er;
        logic       eov;

        vecs[0] = '{8'h30, 8'h20, 13, 8'h18, 8'h00, 1'b0, 8'h18};
        vecs[1] = '{8'h10, 8'h30, 13, 8'h05, 8'h10, 1'b0, 8'h05};
        vecs[2] = '{8'hF0, 8'h01, 13, 8'hFF, 8'h00, 1'b1, 8'h00};
        vecs[3] = '{8'h30, 8'h00,  1, 8'hFF, 8'h30, 1'b1, 8'hFF};
        vecs[4] = '{8'h00, 8'h20, 13, 8'h00, 8'h00, 1'b0, 8'h00};
        vecs[5] = '{8'hFF, 8'hFF, 13, 8'h10, 8'h00, 1'b0, 8'h10};
        vecs[6] = '{8'h01, 8'h03, 13, 8'h05, 8'h01, 1'b0, 8'h05};
        vecs[7] = '{8'h80, 8'h08, 13, 8'hFF, 8'h00, 1'b1, 8'h00};
        vecs[8] = '{8'h25, 8'h07, 13, 8'h54, 8'h04, 1'b0, 8'h54};

        reset = 1'b1; go = 1'b1; left = 8'h30; right = 8'h20;
        repeat (2) @(posedge clk);
        #1;
        check("reset_quotient", q_s, 0);
        check("reset_remainder", r_s, 0);
        check("reset_overflow", ov_s, 0);
        check("reset_done", done_s, 0);
        @(negedge clk);
        reset = 1'b0; go = 1'b0;

        for (int i = 0; i < 9; i++) run_op(vecs[i]);

        // Abort by reset mid-run, then restart two cycles later.
        @(negedge clk);
        go = 1'b1; left = 8'h30; right = 8'h20;
        @(posedge clk); #1;
        for (int c = 1; c <= 19; c++) begin
            @(negedge clk);
            reset = (c == 5);
            go    = (c == 7);
            if (c == 7) begin
                left = 8'h30; right = 8'h20;
            end else begin
                left = 8'($urandom); right = 8'($urandom);
            end
            @(posedge clk); #1;
            check("abort_done", done_s, (c + 1 == 20) ? 1 : 0);
            if (c + 1 == 6) begin
                check("abort_quotient_zero", q_s, 0);
                check("abort_remainder_zero", r_s, 0);
                check("abort_overflow_zero", ov_s, 0);
            end
        end
        check("restart_quotient", q_s, 8'h18);
        check("restart_remainder", r_s, 8'h00);
        @(negedge clk);
        go = 1'b0;
        @(posedge clk); #1;

        // go held high with operands changing every cycle.
        @(negedge clk);
        go = 1'b1;
        l0 = 8'($urandom); r0 = 8'($urandom_range(1, 255));
        l1 = 8'h00; r1 = 8'h01;
        left = l0; right = r0;
        @(posedge clk); #1;
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            left = 8'($urandom); right = 8'($urandom_range(1, 255));
            if (c == 14) begin
                l1 = left; r1 = right;
            end
            @(posedge clk); #1;
            check("stream_done", done_s, (c + 1 == 13 || c + 1 == 27) ? 1 : 0);
            if (c + 1 == 13) begin
                ref_div(l0, r0, eq, er, eov);
                check("stream_q0", q_s, eq);
                check("stream_r0", r_s, er);
                check("stream_ov0", ov_s, eov);
            end
            if (c + 1 == 27) begin
                ref_div(l1, r1, eq, er, eov);
                check("stream_q1", q_s, eq);
                check("stream_r1", r_s, er);
                check("stream_ov1", ov_s, eov);
            end
        end
        @(negedge clk);
        go = 1'b0;
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fixed_p_std_div_pipe.md
FIXED_P_STD_DIV_PIPE -- requirements
Module: fixed_p_std_div_pipe

Interface
REQ-001 Parameter WIDTH, default 32: total operand/result bit width.
REQ-002 Parameter INT_WIDTH, default 8: integer bits; WIDTH SHALL equal INT_WIDTH+FRACT_WIDTH, elaboration error otherwise.
REQ-003 Parameter FRACT_WIDTH, default 24: fractional bits of operands and quotient.
REQ-004 Parameter SATURATE, default 1: on quotient overflow, 1 = clamp to all-ones, 0 = keep low WIDTH bits.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 go  input  1  start request, sampled only in IDLE.
REQ-008 left  input  WIDTH  unsigned fixed-point dividend.
REQ-009 right  input  WIDTH  unsigned fixed-point divisor.
REQ-010 out_quotient  output  WIDTH  registered fixed-point quotient, same format as inputs.
REQ-011 out_remainder  output  WIDTH  registered raw remainder of (left<<FRACT_WIDTH)/right.
REQ-012 overflow  output  1  registered; quotient did not fit in WIDTH bits, or divisor was zero.
REQ-013 done  output  1  one-cycle completion pulse.

Function
REQ-014 States: IDLE, RUN, FIN; reset state IDLE.
REQ-015 IDLE with go=1 and right!=0: latch left, right; load dividend D=WIDTH+FRACT_WIDTH bits = {left, FRACT_WIDTH zeros}; clear partial remainder and iteration counter; go to RUN.
REQ-016 RUN: one restoring-division step per cycle, MSB first, remainder register WIDTH+1 bits; after exactly D steps go to FIN.
REQ-017 FIN: register results, assert done for exactly that cycle, return to IDLE next cycle.
REQ-018 Latency: go accepted in cycle t -> done high in cycle t+D+1; throughput one op per D+2 cycles.
REQ-019 Full quotient is D bits; overflow = any set bit above bit WIDTH-1.
REQ-020 On overflow, out_quotient = all-ones if SATURATE=1, else low WIDTH quotient bits; out_remainder always the true remainder.
REQ-021 IDLE with go=1 and right==0: skip RUN, enter FIN next cycle; out_quotient = all-ones (independent of SATURATE), out_remainder = left, overflow=1; done in cycle t+1.
REQ-022 go, left, right are ignored in RUN and FIN; operand changes after acceptance do not affect the result.
REQ-023 go held high continuously: next operation is accepted in the IDLE cycle following FIN.
REQ-024 out_quotient, out_remainder, overflow hold their last values until the next FIN; done low outside FIN.
REQ-025 Zero dividend: quotient 0, remainder 0, overflow 0, full latency.

Reset
REQ-026 reset=1 at a clock edge: state IDLE, counter 0, out_quotient 0, out_remainder 0, overflow 0, done 0.
REQ-027 reset takes priority over go and aborts RUN/FIN at any point; no done pulse for the aborted operation.
REQ-028 go sampled in the first cycle after reset deassertion is accepted normally.

Structure
REQ-029 The state enum (IDLE, RUN, FIN) SHALL live in the shared fixed-point package fixed_p_pkg; D is a local constant.
REQ-030 One combinational sub-module fixed_p_div_step (one shift-compare-subtract iteration, parameter WIDTH) is natural and SHALL be used.
REQ-031 No multipliers or "/" operators in synthesised logic; block is synthesisable.

Verification (WIDTH=8, INT_WIDTH=4, FRACT_WIDTH=4, D=12)
REQ-032 left=0x30 (3.0), right=0x20 (2.0), go at t -> done at t+13, out_quotient=0x18 (1.5), out_remainder=0x00, overflow=0.
REQ-033 left=0x10 (1.0), right=0x30 (3.0) -> out_quotient=0x05, out_remainder=0x10, overflow=0.
REQ-034 left=0xF0, right=0x01 -> overflow=1; out_quotient=0xFF with SATURATE=1, 0x00 with SATURATE=0; out_remainder=0x00.
REQ-035 left=0x30, right=0x00, go at t -> done at t+1, out_quotient=0xFF, out_remainder=0x30, overflow=1.
REQ-036 go at t, reset at t+5 -> no done through t+20, all outputs 0 from t+6; go at t+7 with 0x30/0x20 -> done at t+20, quotient 0x18.
REQ-037 go held high, operands changed every cycle -> done at t+13 and t+27, each result matching operands present at its acceptance cycle.
